rv_decode_stage: RTL and testbench



---
 rtl/rv_decode_stage_if.sv | 42 ++++
 rtl/rv_decode_stage.sv | 128 ++++++++++++
 tb/tb_rv_decode_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_stage_if.sv
// rtl/rv_decode_stage_if.sv - instruction, register-file, writeback and bundle signals of the decode stage
interface rv_decode_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [31:0]           in_pc;
  logic [AW-1:0]         rs1_addr;
  logic [AW-1:0]         rs2_addr;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [AW-1:0]         wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_wren;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_pc;
  logic [6:0]            out_opcode;
  logic [2:0]            out_funct3;
  logic [6:0]            out_funct7;
  logic [AW-1:0]         out_rd;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [DATA_WIDTH-1:0] out_op1;
  logic [DATA_WIDTH-1:0] out_op2;
  logic                  out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data,
           wb_addr, wb_data, wb_wren, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_opcode,
           out_funct3, out_funct7, out_rd, out_imm, out_op1, out_op2, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data,
           wb_addr, wb_data, wb_wren, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_opcode,
           out_funct3, out_funct7, out_rd, out_imm, out_op1, out_op2, out_illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - RV32I decode stage: regfile addressing, writeback forwarding, decoded bundle
module rv_decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32
) (
  input logic              clk,
  input logic              rst,
  rv_decode_stage_if.slave bus
);
  localparam int AW = $clog2(REG_NUM);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;

  logic                  valid_q;
  logic [31:0]           pc_q;
  logic [6:0]            opcode_q;
  logic [2:0]            funct3_q;
  logic [6:0]            funct7_q;
  logic [AW-1:0]         rd_q;
  logic [AW-1:0]         rs1_q;
  logic [AW-1:0]         rs2_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic                  illegal_q;
  logic                  fwd1_q;
  logic                  fwd2_q;
  logic [DATA_WIDTH-1:0] fwd1_data_q;
  logic [DATA_WIDTH-1:0] fwd2_data_q;

  logic                  ready;
  logic                  accept;
  logic [AW-1:0]         rs1_sel;
  logic [AW-1:0]         rs2_sel;
  logic [31:0]           instr;
  logic signed [31:0]    imm32;
  logic                  dec_illegal;

  assign instr  = bus.in_instr;
  assign ready  = !valid_q || bus.out_ready;
  assign accept = bus.in_valid && ready;

  // Stalled: keep addressing the held registers so rsN_data stays current.
  assign rs1_sel = accept ? instr[15 +: AW] : rs1_q;
  assign rs2_sel = accept ? instr[20 +: AW] : rs2_q;

  always_comb begin
    imm32       = '0;
    dec_illegal = 1'b0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {instr[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_REG, OP_FENCE:
        imm32 = '0;
      default:
        dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      illegal_q   <= 1'b0;
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      fwd1_data_q <= '0;
      fwd2_data_q <= '0;
    end else begin
      if (accept) begin
        valid_q   <= 1'b1;
        pc_q      <= bus.in_pc;
        opcode_q  <= instr[6:0];
        funct3_q  <= instr[14:12];
        funct7_q  <= instr[31:25];
        rd_q      <= instr[7 +: AW];
        rs1_q     <= instr[15 +: AW];
        rs2_q     <= instr[20 +: AW];
        imm_q     <= DATA_WIDTH'(imm32);
        illegal_q <= dec_illegal;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      // The register file returns pre-write data for a same-edge write; capture it here instead.
      fwd1_q      <= bus.wb_wren && (bus.wb_addr == rs1_sel) && (bus.wb_addr != '0);
      fwd2_q      <= bus.wb_wren && (bus.wb_addr == rs2_sel) && (bus.wb_addr != '0);
      fwd1_data_q <= bus.wb_data;
      fwd2_data_q <= bus.wb_data;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.rs1_addr    = rs1_sel;
  assign bus.rs2_addr    = rs2_sel;
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_opcode  = opcode_q;
  assign bus.out_funct3  = funct3_q;
  assign bus.out_funct7  = funct7_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_illegal = illegal_q;
  assign bus.out_op1     = (rs1_q == '0) ? '0 : (fwd1_q ? fwd1_data_q : bus.rs1_data);
  assign bus.out_op2     = (rs2_q == '0) ? '0 : (fwd2_q ? fwd2_data_q : bus.rs2_data);
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - directed and randomized checks of rv_decode_stage against a behavioural model
module tb_rv_decode_stage;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  rv_decode_stage_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();
  rv_decode_stage #(.DATA_WIDTH(DW), .REG_NUM(RN)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Register file: registered read that returns pre-write contents; regs is also the architectural state.
  logic [DW-1:0] regs [RN];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RN; k++) regs[k] <= '0;
      bus.rs1_data <= '0;
      bus.rs2_data <= '0;
    end else begin
      bus.rs1_data <= regs[bus.rs1_addr];
      bus.rs2_data <= regs[bus.rs2_addr];
      if (bus.wb_wren && bus.wb_addr != '0) regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_imm(input logic [31:0] i);
    int v;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: v = int'($signed(i[31:20]));
      7'h23:                      v = int'($signed({i[31:25], i[11:7]}));
      7'h63:                      v = int'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
      7'h37, 7'h17:               v = int'(i & 32'hFFFF_F000);
      7'h6F:                      v = int'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
      default:                    v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic exp_illegal(input logic [31:0] i);
    return !(i[6:0] inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F});
  endfunction

  function automatic logic [DW-1:0] exp_op(input logic [4:0] r);
    return (r == 5'd0) ? '0 : regs[r];
  endfunction

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 1'b1; bus.wb_wren = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.out_illegal !== 1'b0 || bus.out_imm !== '0) $display("FAIL reset_fields: illegal %b imm %h want 0 0", bus.out_illegal, bus.out_imm); else passed++;
  endtask

  task automatic test_addi();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0050_0093; bus.in_pc = 32'h100; bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_imm !== 32'd5) $display("FAIL addi_imm: got %h want 5", bus.out_imm); else passed++;
    total++; if (bus.out_rd !== 5'd1) $display("FAIL addi_rd: got %0d want 1", bus.out_rd); else passed++;
    total++; if (bus.out_op1 !== '0) $display("FAIL addi_op1: got %h want 0", bus.out_op1); else passed++;
    total++; if (bus.out_illegal !== 1'b0 || bus.out_pc !== 32'h100) $display("FAIL addi_misc: illegal %b pc %h want 0 100", bus.out_illegal, bus.out_pc); else passed++;
    cyc();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL addi_drain: got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_operands();
    bus.wb_wren = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h11;
    cyc();
    bus.wb_addr = 5'd3; bus.wb_data = 32'h22;
    cyc();
    bus.wb_wren = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0031_0233; bus.in_pc = 32'h104;
    cyc();
    bus.in_valid = 1'b0;
    total++; if (bus.out_op1 !== 32'h11) $display("FAIL add_op1: got %h want 11", bus.out_op1); else passed++;
    total++; if (bus.out_op2 !== 32'h22) $display("FAIL add_op2: got %h want 22", bus.out_op2); else passed++;
    total++; if (bus.out_rd !== 5'd4 || bus.out_illegal !== 1'b0) $display("FAIL add_rd: rd %0d illegal %b want 4 0", bus.out_rd, bus.out_illegal); else passed++;
    cyc();
  endtask

  task automatic test_forward();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0031_0233; bus.in_pc = 32'h108; bus.out_ready = 1'b0;
    bus.wb_wren = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'hAB;
    cyc();
    bus.in_valid = 1'b0; bus.wb_wren = 1'b0;
    total++; if (bus.out_op1 !== 32'hAB) $display("FAIL fwd_op1: got %h want ab", bus.out_op1); else passed++;
    total++; if (bus.out_op2 !== 32'h22) $display("FAIL fwd_op2: got %h want 22", bus.out_op2); else passed++;
  endtask

  task automatic test_stall();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000_0013; bus.in_pc = 32'h10C; bus.out_ready = 1'b0;
    bus.wb_wren = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h77;
    #1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", bus.in_ready); else passed++;
    for (int c = 0; c < 3; c++) begin
      cyc();
      bus.wb_wren = 1'b0;
      total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h108 || bus.out_rd !== 5'd4 || bus.in_ready !== 1'b0)
        $display("FAIL stall_hold%0d: valid %b pc %h rd %0d ready %b want 1 108 4 0", c, bus.out_valid, bus.out_pc, bus.out_rd, bus.in_ready); else passed++;
      total++; if (bus.out_op1 !== 32'hAB || bus.out_op2 !== 32'h77)
        $display("FAIL stall_ops%0d: op1 %h op2 %h want ab 77", c, bus.out_op1, bus.out_op2); else passed++;
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL stall_release: got %b want 1", bus.in_ready); else passed++;
    cyc();
    total++; if (bus.out_pc !== 32'h10C || bus.out_valid !== 1'b1) $display("FAIL stall_next: pc %h valid %b want 10c 1", bus.out_pc, bus.out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [4];
    prog[0] = 32'h1234_52B7; prog[1] = 32'hFE00_0CE3; prog[2] = 32'h0080_006F; prog[3] = 32'hFFC1_2E23;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = prog[i]; bus.in_pc = 32'h200 + 32'(4 * i);
      cyc();
      total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 + 32'(4 * i))
        $display("FAIL b2b_seq%0d: valid %b pc %h want 1 %h", i, bus.out_valid, bus.out_pc, 32'h200 + 32'(4 * i)); else passed++;
      total++; if (bus.out_imm !== exp_imm(prog[i])) $display("FAIL b2b_imm%0d: got %h want %h", i, bus.out_imm, exp_imm(prog[i])); else passed++;
      if (i == 1) begin
        total++; if (bus.out_imm !== 32'hFFFF_FFF8) $display("FAIL beq_imm: got %h want fffffff8", bus.out_imm); else passed++;
      end
    end
    bus.in_valid = 1'b0;
    cyc();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_end: got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_illegal_reset();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000_007F; bus.in_pc = 32'h300; bus.out_ready = 1'b0;
    cyc();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_imm !== '0)
      $display("FAIL illegal: valid %b illegal %b imm %h want 1 1 0", bus.out_valid, bus.out_illegal, bus.out_imm); else passed++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.out_pc !== '0) $display("FAIL midreset: valid %b pc %h want 0 0", bus.out_valid, bus.out_pc); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] q_instr [$];
    logic [31:0] q_pc [$];
    logic [6:0]  ops [13];
    logic [31:0] ins, hi;
    logic        acc, exp_ready;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00, 7'h0B};
    rst = 1'b1; bus.in_valid = 1'b0; bus.wb_wren = 1'b0;
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 12)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = ins;
      bus.in_pc     = $urandom & 32'hFFFF_FFFC;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.wb_wren   = 1'($urandom_range(0, 1));
      bus.wb_addr   = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      exp_ready = (q_instr.size() == 0) || bus.out_ready;
      acc = bus.in_valid && exp_ready;
      #1;
      total++; if (bus.in_ready !== exp_ready) $display("FAIL rnd_ready@%0d: got %b want %b", n, bus.in_ready, exp_ready); else passed++;
      total++; if (bus.out_valid !== (q_instr.size() != 0)) $display("FAIL rnd_valid@%0d: got %b want %b", n, bus.out_valid, q_instr.size() != 0); else passed++;
      if (q_instr.size() != 0) begin
        hi = q_instr[0];
        total++; if (bus.out_pc !== q_pc[0] || bus.out_opcode !== hi[6:0] || bus.out_funct3 !== hi[14:12] || bus.out_funct7 !== hi[31:25] || bus.out_rd !== hi[11:7])
          $display("FAIL rnd_fields@%0d: pc %h op %h rd %0d want %h %h %0d", n, bus.out_pc, bus.out_opcode, bus.out_rd, q_pc[0], hi[6:0], hi[11:7]); else passed++;
        total++; if (bus.out_imm !== exp_imm(hi) || bus.out_illegal !== exp_illegal(hi))
          $display("FAIL rnd_imm@%0d: imm %h illegal %b want %h %b", n, bus.out_imm, bus.out_illegal, exp_imm(hi), exp_illegal(hi)); else passed++;
        total++; if (bus.out_op1 !== exp_op(hi[19:15]) || bus.out_op2 !== exp_op(hi[24:20]))
          $display("FAIL rnd_ops@%0d: op1 %h op2 %h want %h %h", n, bus.out_op1, bus.out_op2, exp_op(hi[19:15]), exp_op(hi[24:20])); else passed++;
        if (bus.out_ready) begin
          void'(q_instr.pop_front());
          void'(q_pc.pop_front());
        end
      end
      if (acc) begin
        q_instr.push_back(ins);
        q_pc.push_back(bus.in_pc);
      end
      cyc();
    end
    bus.in_valid = 1'b0; bus.wb_wren = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_operands();
    test_forward();
    test_stall();
    test_back_to_back();
    test_illegal_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
